cordic_share_arbiter: RTL

//  - Shares one cordic_rotation_fixed unit between NREQ requesters in the matrix-inversion datapath.
//  - Requesters are Givens/QR row engines. Each presents operands (x, y, theta) with a level request.
//  - The block grants requesters round-robin, latches the winner's operands and pulses the CORDIC valid.
//  - It waits for done, then returns x/y/z tagged with the requester id.

---
 rtl/cordic_pkg.sv | 21 ++
 rtl/cordic_rr_pick.sv | 31 +++
 rtl/cordic_share_arbiter.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/cordic_pkg.sv
// Shared definitions for the CORDIC share arbiter: word-size defaults,
// FSM state type and the requester-id width helper.
package cordic_pkg;

    localparam int unsigned WL_DEF      = 16;
    localparam int unsigned FL_DEF      = 12;
    localparam int unsigned TIMEOUT_DEF = 64;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } state_e;

    // A single requester still needs one id bit to keep vectors legal.
    function automatic int unsigned id_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cordic_rr_pick.sv
// Combinational round-robin picker: first set request at or after the
// pointer, wrapping, as a one-hot winner plus its binary id.
module cordic_rr_pick #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = 2
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  ptr_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IDW-1:0]  id_o,
    output logic            any_o
);

    logic [IDW-1:0] idx;

    always_comb begin
        gnt_o = '0;
        id_o  = '0;
        any_o = 1'b0;
        idx   = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = IDW'((32'(ptr_i) + k) % NREQ);
            if (!any_o && req_i[idx]) begin
                any_o      = 1'b1;
                gnt_o[idx] = 1'b1;
                id_o       = idx;
            end
        end
    end

endmodule

// File: rtl/cordic_share_arbiter.sv
// Round-robin sharing of one CORDIC rotation unit between NREQ requesters.
// Optional watchdog on the CORDIC done handshake: define CORDIC_TIMEOUT_EN.
module cordic_share_arbiter
    import cordic_pkg::*;
#(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned WL      = WL_DEF,
    parameter int unsigned FL      = FL_DEF,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*WL-1:0] req_x,
    input  logic [NREQ*WL-1:0] req_y,
    input  logic [NREQ*WL-1:0] req_theta,
    output logic [NREQ-1:0]    gnt,
    output logic [NREQ-1:0]    rsp_valid,
    output logic [WL-1:0]      rsp_x,
    output logic [WL-1:0]      rsp_y,
    output logic [WL-1:0]      rsp_z,
    output logic               rsp_err,
    output logic               busy,
    output logic               cordic_valid,
    output logic [WL-1:0]      cordic_x,
    output logic [WL-1:0]      cordic_y,
    output logic [WL-1:0]      cordic_th,
    input  logic [WL-1:0]      cordic_xo,
    input  logic [WL-1:0]      cordic_yo,
    input  logic [WL-1:0]      cordic_zo,
    input  logic               cordic_done
);

    localparam int unsigned IDW = id_width(NREQ);

    if (NREQ < 1 || NREQ > 8) begin : g_bad_nreq
        $error("cordic_share_arbiter: NREQ must be 1..8");
    end
    if (FL >= WL) begin : g_bad_fl
        $error("cordic_share_arbiter: FL must be below WL");
    end
    if (TIMEOUT == 0) begin : g_bad_timeout
        $error("cordic_share_arbiter: TIMEOUT must be nonzero");
    end

    state_e          state_q, state_d;
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [IDW-1:0]  id_q, id_d;
    logic [WL-1:0]   op_x_q, op_x_d, op_y_q, op_y_d, op_t_q, op_t_d;
    logic [WL-1:0]   res_x_q, res_x_d, res_y_q, res_y_d, res_z_q, res_z_d;
    logic            err_q, err_d;
    logic            done_q;
    logic            done_rise;
    logic            expired;

    logic [NREQ-1:0] pick_gnt;
    logic [IDW-1:0]  pick_id;
    logic            pick_any;

    cordic_rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .req_i (req),
        .ptr_i (ptr_q),
        .gnt_o (pick_gnt),
        .id_o  (pick_id),
        .any_o (pick_any)
    );

    // done_q follows the level in every state so a held-high done cannot re-fire.
    assign done_rise = cordic_done & ~done_q;

`ifdef CORDIC_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT + 1) + 1;
    logic [CW-1:0] wdog_q, wdog_d;

    assign wdog_d  = (state_q == ST_WAIT) ? wdog_q + 1'b1 : '0;
    assign expired = (wdog_q == CW'(TIMEOUT));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) wdog_q <= '0;
        else      wdog_q <= wdog_d;
    end
`else
    assign expired = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        op_x_d  = op_x_q;
        op_y_d  = op_y_q;
        op_t_d  = op_t_q;
        res_x_d = res_x_q;
        res_y_d = res_y_q;
        res_z_d = res_z_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    id_d    = pick_id;
                    op_x_d  = req_x[32'(pick_id)*WL +: WL];
                    op_y_d  = req_y[32'(pick_id)*WL +: WL];
                    op_t_d  = req_theta[32'(pick_id)*WL +: WL];
                    state_d = ST_LAUNCH;
                end
            end
            ST_LAUNCH: state_d = ST_WAIT;
            ST_WAIT: begin
                if (done_rise) begin
                    res_x_d = cordic_xo;
                    res_y_d = cordic_yo;
                    res_z_d = cordic_zo;
                    err_d   = 1'b0;
                    state_d = ST_RESP;
                end else if (expired) begin
                    res_x_d = '0;
                    res_y_d = '0;
                    res_z_d = '0;
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                ptr_d   = (32'(id_q) == NREQ - 1) ? '0 : id_q + 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            id_q    <= '0;
            op_x_q  <= '0;
            op_y_q  <= '0;
            op_t_q  <= '0;
            res_x_q <= '0;
            res_y_q <= '0;
            res_z_q <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            op_x_q  <= op_x_d;
            op_y_q  <= op_y_d;
            op_t_q  <= op_t_d;
            res_x_q <= res_x_d;
            res_y_q <= res_y_d;
            res_z_q <= res_z_d;
            err_q   <= err_d;
            done_q  <= cordic_done;
        end
    end

    always_comb begin
        gnt       = '0;
        rsp_valid = '0;
        if (state_q == ST_LAUNCH) gnt[id_q]       = 1'b1;
        if (state_q == ST_RESP)   rsp_valid[id_q] = 1'b1;
    end

    assign cordic_valid = (state_q == ST_LAUNCH);
    assign busy         = (state_q != ST_IDLE);
    assign cordic_x     = op_x_q;
    assign cordic_y     = op_y_q;
    assign cordic_th    = op_t_q;
    assign rsp_x        = res_x_q;
    assign rsp_y        = res_y_q;
    assign rsp_z        = res_z_q;
    assign rsp_err      = err_q;

endmodule
